// File: rtl/axis_master_data_gen_test.sv
// rtl/axis_master_data_gen_test.sv - AXI4-Stream master emitting one packet of incrementing words per START.
// Optional TVALID gap insertion is compiled in with AXIS_GEN_GAP_EN.
module axis_master_data_gen_test #(
    parameter int                                C_M_AXIS_TDATA_WIDTH   = 32,
    parameter int                                NUMBER_OF_OUTPUT_WORDS = 1024,
    parameter int                                C_M_START_COUNT        = 32,
    parameter logic [C_M_AXIS_TDATA_WIDTH-1:0]   DATA_BASE              = '0,
    parameter int                                GAP_PERIOD             = 4,
    parameter int                                GAP_CYCLES             = 100
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESETN,
    input  logic                                START,
    output logic                                BUSY,
    output logic                                DONE,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY
);

    localparam int IDX_W  = (NUMBER_OF_OUTPUT_WORDS > 1) ? $clog2(NUMBER_OF_OUTPUT_WORDS) : 1;
    localparam int WAIT_W = $clog2(C_M_START_COUNT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUMBER_OF_OUTPUT_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(C_M_START_COUNT);

    if (C_M_AXIS_TDATA_WIDTH % 8 != 0 || NUMBER_OF_OUTPUT_WORDS < 1 || C_M_START_COUNT < 1 ||
        GAP_PERIOD < 1 || GAP_CYCLES < 1) begin : g_bad_params
        $error("axis_master_data_gen_test: invalid parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_SEND, S_GAP} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              done_q;
    logic              last_beat;

    assign last_beat = (idx == LAST_IDX);

`ifdef AXIS_GEN_GAP_EN
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GPER_W = (GAP_PERIOD > 1) ? $clog2(GAP_PERIOD) : 1;

    logic [GAP_W-1:0]  gap_cnt;
    logic [GPER_W-1:0] per_cnt;
    logic              gap_due;

    // per_cnt counts beats accepted since the packet start or the last gap
    assign gap_due = (per_cnt == GPER_W'(GAP_PERIOD - 1));
`endif

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state    <= S_IDLE;
            idx      <= '0;
            wait_cnt <= '0;
            done_q   <= 1'b0;
`ifdef AXIS_GEN_GAP_EN
            gap_cnt  <= '0;
            per_cnt  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // the DONE cycle still counts as busy for START purposes
                    if (START && !done_q) begin
                        state    <= S_INIT;
                        wait_cnt <= '0;
                        idx      <= '0;
`ifdef AXIS_GEN_GAP_EN
                        per_cnt  <= '0;
`endif
                    end
                end
                S_INIT: begin
                    if (wait_cnt == WAIT_END) begin
                        state <= S_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_SEND: begin
                    if (M_AXIS_TREADY) begin
                        if (last_beat) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
`ifdef AXIS_GEN_GAP_EN
                            if (gap_due) begin
                                state   <= S_GAP;
                                gap_cnt <= '0;
                                per_cnt <= '0;
                            end else begin
                                per_cnt <= per_cnt + GPER_W'(1);
                            end
`endif
                        end
                    end
                end
`ifdef AXIS_GEN_GAP_EN
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign M_AXIS_TVALID = (state == S_SEND);
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? (DATA_BASE + C_M_AXIS_TDATA_WIDTH'(idx)) : '0;
    assign M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){M_AXIS_TVALID}};
    assign M_AXIS_TLAST  = M_AXIS_TVALID && last_beat;
    assign BUSY          = (state != S_IDLE);
    assign DONE          = done_q;

endmodule
